// File: rtl/fma_mid_pkg.sv
// rtl/fma_mid_pkg.sv - shared types, widths and redirect kill check for the FMA mid-result relay
//
// Purpose : widths of the FMA multiply-stage intermediate result, the
//           mid-result and robIdx structs, and the robIdx age / flush test
//           shared by every redirect-aware block.
// Ports   : none (package).
package fma_mid_pkg;

    localparam int ROB_W = 5;
    localparam int EXP_W = 11;
    localparam int SIG_W = 105;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [SIG_W-1:0] sig;
        logic             is_nan;
        logic             is_inf;
        logic             is_inv;
        logic             overflow;
    } mid_result_t;

    typedef struct packed {
        logic             flag;
        logic [ROB_W-1:0] value;
    } rob_idx_t;

    // a is younger than b; the flag bit flips each time the ROB index wraps
    function automatic logic is_after(input rob_idx_t a, input rob_idx_t b);
        return (a.flag ^ b.flag) ^ (a.value > b.value);
    endfunction

    // level=1 also flushes the redirecting uop itself
    function automatic logic need_flush(input rob_idx_t r, input logic redir_valid,
                                        input rob_idx_t redir, input logic redir_level);
        return redir_valid && (is_after(r, redir) || (redir_level && (r == redir)));
    endfunction

endpackage

// File: rtl/fma_mid_relay_if.sv
// rtl/fma_mid_relay_if.sv - fmaMid interface bundle between producer, relay and consumer
//
// Purpose : groups the enqueue (producer midResult), redirect and dequeue
//           (consumer midResult_in) signals of the relay.
// Modports: master - drives enq_*, redirect_*, mid_ready; observes the rest
//           slave  - the relay itself
interface fma_mid_relay_if
    import fma_mid_pkg::*;
#(
    parameter int DEPTH = 2
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             enq_valid;
    logic             enq_ready;
    logic             enq_sign;
    logic [EXP_W-1:0] enq_exp;
    logic [SIG_W-1:0] enq_sig;
    logic             enq_isNaN;
    logic             enq_isInf;
    logic             enq_isInv;
    logic             enq_overflow;
    logic             enq_robIdx_flag;
    logic [ROB_W-1:0] enq_robIdx_value;

    logic             redirect_valid;
    logic             redirect_robIdx_flag;
    logic [ROB_W-1:0] redirect_robIdx_value;
    logic             redirect_level;

    logic             mid_valid;
    logic             mid_ready;
    logic             mid_sign;
    logic [EXP_W-1:0] mid_exp;
    logic [SIG_W-1:0] mid_sig;
    logic             mid_isNaN;
    logic             mid_isInf;
    logic             mid_isInv;
    logic             mid_overflow;
    logic             mid_robIdx_flag;
    logic [ROB_W-1:0] mid_robIdx_value;
    logic             waitForAdd;
    logic [CNT_W-1:0] count;

    modport master (
        output enq_valid, enq_sign, enq_exp, enq_sig, enq_isNaN, enq_isInf, enq_isInv,
               enq_overflow, enq_robIdx_flag, enq_robIdx_value,
               redirect_valid, redirect_robIdx_flag, redirect_robIdx_value, redirect_level,
               mid_ready,
        input  enq_ready, mid_valid, mid_sign, mid_exp, mid_sig, mid_isNaN, mid_isInf,
               mid_isInv, mid_overflow, mid_robIdx_flag, mid_robIdx_value, waitForAdd, count
    );

    modport slave (
        input  enq_valid, enq_sign, enq_exp, enq_sig, enq_isNaN, enq_isInf, enq_isInv,
               enq_overflow, enq_robIdx_flag, enq_robIdx_value,
               redirect_valid, redirect_robIdx_flag, redirect_robIdx_value, redirect_level,
               mid_ready,
        output enq_ready, mid_valid, mid_sign, mid_exp, mid_sig, mid_isNaN, mid_isInf,
               mid_isInv, mid_overflow, mid_robIdx_flag, mid_robIdx_value, waitForAdd, count
    );

endinterface

// File: rtl/fma_mid_flush_cmp.sv
// rtl/fma_mid_flush_cmp.sv - combinational redirect kill predicate for one robIdx
//
// Purpose : kill = redirect_valid && (rob younger than redirect ||
//           (redirect_level && rob == redirect)).
// Ports   : rob            - robIdx under test
//           redirect_valid - flush request
//           redirect_rob   - redirecting robIdx
//           redirect_level - also flush the redirecting uop
//           kill           - entry must be dropped
module fma_mid_flush_cmp
    import fma_mid_pkg::*;
(
    input  rob_idx_t rob,
    input  logic     redirect_valid,
    input  rob_idx_t redirect_rob,
    input  logic     redirect_level,
    output logic     kill
);

    assign kill = need_flush(rob, redirect_valid, redirect_rob, redirect_level);

endmodule

// File: rtl/fma_mid_relay.sv
// rtl/fma_mid_relay.sv - in-order buffer for FMA mid results with redirect flush
//
// Purpose : circular buffer of DEPTH mid results between the producing and
//           consuming FMA exe units. Entries killed by a redirect stay in
//           place as dead slots and drain one per cycle to preserve order.
// Ports   : clock - sole clock
//           reset - asynchronous, active-low
//           io    - fmaMid bundle (slave side): enq_*, redirect_*, mid_*,
//                   waitForAdd, count
module fma_mid_relay
    import fma_mid_pkg::*;
#(
    parameter int DEPTH = 2
)(
    input  logic             clock,
    input  logic             reset,
    fma_mid_relay_if.slave   io
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [DEPTH-1:0] alive_q, alive_d;
    mid_result_t      pay_q [DEPTH];
    mid_result_t      pay_d [DEPTH];
    rob_idx_t         rob_q [DEPTH];
    rob_idx_t         rob_d [DEPTH];

    rob_idx_t         redir_rob;
    rob_idx_t         enq_rob;
    mid_result_t      enq_pay;
    logic [DEPTH-1:0] slot_kill;
    logic             enq_kill;

    logic [PTR_W-1:0] occ;
    logic             full;
    logic             empty;
    logic [IDX_W-1:0] head_idx;
    logic [IDX_W-1:0] tail_idx;
    logic [IDX_W-1:0] off;
    logic             head_alive;
    logic             head_kill;
    logic             mid_valid_c;
    logic             enq_fire;
    logic             pop;
    logic             wait_c;

    assign redir_rob = {io.redirect_robIdx_flag, io.redirect_robIdx_value};
    assign enq_rob   = {io.enq_robIdx_flag, io.enq_robIdx_value};
    assign enq_pay   = {io.enq_sign, io.enq_exp, io.enq_sig,
                        io.enq_isNaN, io.enq_isInf, io.enq_isInv, io.enq_overflow};

    for (genvar i = 0; i < DEPTH; i++) begin : g_slot_cmp
        fma_mid_flush_cmp u_cmp (
            .rob            (rob_q[i]),
            .redirect_valid (io.redirect_valid),
            .redirect_rob   (redir_rob),
            .redirect_level (io.redirect_level),
            .kill           (slot_kill[i])
        );
    end

    // A result arriving during a redirect that targets it is stored dead
    fma_mid_flush_cmp u_enq_cmp (
        .rob            (enq_rob),
        .redirect_valid (io.redirect_valid),
        .redirect_rob   (redir_rob),
        .redirect_level (io.redirect_level),
        .kill           (enq_kill)
    );

    always_comb begin
        occ         = tail_q - head_q;
        full        = (head_q ^ tail_q) == PTR_W'(DEPTH);
        empty       = head_q == tail_q;
        head_idx    = head_q[IDX_W-1:0];
        tail_idx    = tail_q[IDX_W-1:0];
        head_alive  = alive_q[head_idx];
        head_kill   = slot_kill[head_idx];
        mid_valid_c = !empty && head_alive && !head_kill;
        enq_fire    = io.enq_valid && !full;
        // A dead head drains on its own; a head killed this cycle is still
        // alive in the flop, so it waits one cycle and drains as dead.
        pop         = !empty && ((mid_valid_c && io.mid_ready) || !head_alive);

        wait_c = 1'b0;
        off    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off = IDX_W'(i) - head_idx;
            if (({1'b0, off} < occ) && alive_q[i] && !slot_kill[i]) begin
                wait_c = 1'b1;
            end
        end

        head_d  = head_q + PTR_W'(pop);
        tail_d  = tail_q + PTR_W'(enq_fire);
        alive_d = alive_q & ~slot_kill;
        pay_d   = pay_q;
        rob_d   = rob_q;
        if (pop) begin
            alive_d[head_idx] = 1'b0;
        end
        if (enq_fire) begin
            pay_d[tail_idx]   = enq_pay;
            rob_d[tail_idx]   = enq_rob;
            alive_d[tail_idx] = !enq_kill;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            alive_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pay_q[i] <= '0;
                rob_q[i] <= '0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            alive_q <= alive_d;
            pay_q   <= pay_d;
            rob_q   <= rob_d;
        end
    end

    assign io.enq_ready        = !full;
    assign io.mid_valid        = mid_valid_c;
    assign io.mid_sign         = pay_q[head_idx].sign;
    assign io.mid_exp          = pay_q[head_idx].exp;
    assign io.mid_sig          = pay_q[head_idx].sig;
    assign io.mid_isNaN        = pay_q[head_idx].is_nan;
    assign io.mid_isInf        = pay_q[head_idx].is_inf;
    assign io.mid_isInv        = pay_q[head_idx].is_inv;
    assign io.mid_overflow     = pay_q[head_idx].overflow;
    assign io.mid_robIdx_flag  = rob_q[head_idx].flag;
    assign io.mid_robIdx_value = rob_q[head_idx].value;
    assign io.waitForAdd       = wait_c;
    assign io.count            = occ;

    // Producer must hold its result while the buffer is full
    a_enq_hold : assert property (@(posedge clock) disable iff (!reset)
                                  !(io.enq_valid && !io.enq_ready));

endmodule

// File: tb/tb_fma_mid_relay.sv
// tb/tb_fma_mid_relay.sv - directed self-checking bench for fma_mid_relay
module tb_fma_mid_relay;
    import fma_mid_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   n_vec = 0;
    int   n_bad = 0;

    always #5 clock = ~clock;

    fma_mid_relay_if #(.DEPTH(2)) io ();

    fma_mid_relay #(.DEPTH(2)) dut (
        .clock (clock),
        .reset (reset),
        .io    (io)
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic put(input logic v, input logic f, input logic [ROB_W-1:0] val,
                       input logic s, input logic [EXP_W-1:0] e, input logic [SIG_W-1:0] g);
        io.enq_valid        = v;
        io.enq_robIdx_flag  = f;
        io.enq_robIdx_value = val;
        io.enq_sign         = s;
        io.enq_exp          = e;
        io.enq_sig          = g;
        io.enq_isNaN        = 1'b0;
        io.enq_isInf        = 1'b0;
        io.enq_isInv        = 1'b0;
        io.enq_overflow     = 1'b0;
    endtask

    task automatic redir(input logic v, input logic f, input logic [ROB_W-1:0] val,
                         input logic lvl);
        io.redirect_valid        = v;
        io.redirect_robIdx_flag  = f;
        io.redirect_robIdx_value = val;
        io.redirect_level        = lvl;
    endtask

    initial begin
        logic [SIG_W-1:0] big_sig;
        big_sig = '0;
        big_sig[104] = 1'b1;

        put(0, 0, 0, 0, '0, '0);
        redir(0, 0, 0, 0);
        io.mid_ready = 1'b0;

        // reset state
        #12;
        chk("rst_enq_ready", io.enq_ready, 1);
        chk("rst_mid_valid", io.mid_valid, 0);
        chk("rst_wait", io.waitForAdd, 0);
        chk("rst_count", io.count, 0);
        chk("rst_sig", io.mid_sig, 0);
        reset = 1'b1;
        tick();

        // basic enqueue / dequeue; mid_ready while empty is ignored
        io.mid_ready = 1'b1;
        put(1, 0, 3, 1, 11'h3FF, big_sig);
        settle();
        chk("b_lat_valid", io.mid_valid, 0);
        tick();
        put(0, 0, 0, 0, '0, '0);
        settle();
        chk("b_valid", io.mid_valid, 1);
        chk("b_sign", io.mid_sign, 1);
        chk("b_exp", io.mid_exp, 11'h3FF);
        chk("b_sig", io.mid_sig, big_sig);
        chk("b_rob", {io.mid_robIdx_flag, io.mid_robIdx_value}, 6'd3);
        chk("b_wait", io.waitForAdd, 1);
        chk("b_count1", io.count, 1);
        tick();
        settle();
        chk("b_count0", io.count, 0);
        chk("b_wait0", io.waitForAdd, 0);
        chk("b_valid0", io.mid_valid, 0);

        // full and back-pressure
        io.mid_ready = 1'b0;
        put(1, 0, 1, 0, 11'd1, 105'd1);
        tick();
        put(1, 0, 2, 0, 11'd2, 105'd2);
        tick();
        put(0, 0, 0, 0, '0, '0);
        settle();
        chk("f_count2", io.count, 2);
        chk("f_ready0", io.enq_ready, 0);
        chk("f_head1", io.mid_robIdx_value, 1);
        tick();
        io.mid_ready = 1'b1;
        settle();
        chk("f_pop_valid", io.mid_valid, 1);
        chk("f_ready_still0", io.enq_ready, 0);
        tick();
        io.mid_ready = 1'b0;
        settle();
        chk("f_ready1", io.enq_ready, 1);
        chk("f_count1", io.count, 1);
        chk("f_head2", io.mid_robIdx_value, 2);
        put(1, 0, 7, 0, 11'd7, 105'd7);
        tick();
        put(0, 0, 0, 0, '0, '0);
        io.mid_ready = 1'b1;
        settle();
        chk("f_count2b", io.count, 2);
        chk("f_exp2", io.mid_exp, 11'd2);
        tick();
        settle();
        chk("f_head7", io.mid_robIdx_value, 7);
        chk("f_sig7", io.mid_sig, 105'd7);
        tick();
        io.mid_ready = 1'b0;
        settle();
        chk("f_empty", io.count, 0);

        // redirect flushes the younger entry only
        put(1, 0, 4, 0, 11'd4, 105'd4);
        tick();
        put(1, 0, 6, 0, 11'd6, 105'd6);
        tick();
        put(0, 0, 0, 0, '0, '0);
        redir(1, 0, 5, 0);
        settle();
        chk("r_valid", io.mid_valid, 1);
        chk("r_wait", io.waitForAdd, 1);
        tick();
        redir(0, 0, 0, 0);
        settle();
        chk("r_count2", io.count, 2);
        chk("r_head4", io.mid_robIdx_value, 4);
        io.mid_ready = 1'b1;
        tick();
        io.mid_ready = 1'b0;
        settle();
        chk("r_dead_valid", io.mid_valid, 0);
        chk("r_dead_count", io.count, 1);
        chk("r_dead_wait", io.waitForAdd, 0);
        tick();
        settle();
        chk("r_drained", io.count, 0);

        // level=1 kills the head in the cycle it would be consumed
        put(1, 0, 5, 0, 11'd5, 105'd5);
        tick();
        put(0, 0, 0, 0, '0, '0);
        io.mid_ready = 1'b1;
        redir(1, 0, 5, 1);
        settle();
        chk("l_valid0", io.mid_valid, 0);
        chk("l_wait0", io.waitForAdd, 0);
        tick();
        redir(0, 0, 0, 0);
        io.mid_ready = 1'b0;
        settle();
        chk("l_count1", io.count, 1);
        chk("l_dead_valid", io.mid_valid, 0);
        tick();
        settle();
        chk("l_count0", io.count, 0);

        // robIdx flag wrap: (1,1) is younger than (0,30), (0,29) is older
        put(1, 1, 1, 0, 11'd1, 105'd1);
        tick();
        put(1, 0, 29, 0, 11'd29, 105'd29);
        tick();
        put(0, 0, 0, 0, '0, '0);
        redir(1, 0, 30, 0);
        settle();
        chk("w_count2", io.count, 2);
        chk("w_head_killed", io.mid_valid, 0);
        chk("w_wait", io.waitForAdd, 1);
        tick();
        redir(0, 0, 0, 0);
        settle();
        chk("w_dead_valid", io.mid_valid, 0);
        tick();
        settle();
        chk("w_count1", io.count, 1);
        chk("w_kept_valid", io.mid_valid, 1);
        chk("w_kept_rob", {io.mid_robIdx_flag, io.mid_robIdx_value}, 6'd29);
        io.mid_ready = 1'b1;
        tick();
        io.mid_ready = 1'b0;
        settle();
        chk("w_empty", io.count, 0);

        // result arriving during its own flush is stored dead
        put(1, 0, 12, 0, 11'd12, 105'd12);
        redir(1, 0, 10, 0);
        tick();
        put(0, 0, 0, 0, '0, '0);
        redir(0, 0, 0, 0);
        settle();
        chk("e_count1", io.count, 1);
        chk("e_valid0", io.mid_valid, 0);
        chk("e_wait0", io.waitForAdd, 0);
        tick();
        settle();
        chk("e_count0", io.count, 0);

        // asynchronous reset with two entries held
        put(1, 0, 8, 0, 11'd8, 105'd8);
        tick();
        put(1, 0, 9, 0, 11'd9, 105'd9);
        tick();
        put(0, 0, 0, 0, '0, '0);
        #2;
        chk("a_pre_count", io.count, 2);
        reset = 1'b0;
        #1;
        chk("a_valid0", io.mid_valid, 0);
        chk("a_wait0", io.waitForAdd, 0);
        chk("a_count0", io.count, 0);
        chk("a_ready1", io.enq_ready, 1);
        #2;
        reset = 1'b1;
        tick();
        put(1, 0, 9, 1, 11'h155, 105'd99);
        settle();
        chk("a_lat_valid", io.mid_valid, 0);
        tick();
        put(0, 0, 0, 0, '0, '0);
        settle();
        chk("a_valid1", io.mid_valid, 1);
        chk("a_rob9", io.mid_robIdx_value, 9);
        chk("a_exp", io.mid_exp, 11'h155);
        chk("a_count1", io.count, 1);
        io.mid_ready = 1'b1;
        tick();
        io.mid_ready = 1'b0;
        settle();
        chk("a_count0b", io.count, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/fma_mid_relay.md
Name: fma_mid_relay

Overview:
- Buffers FMA multiply-stage intermediate results (prod sign/exp/sig plus inter flags) from a producing FMA exe unit's midResult output.
- Presents them in order to the consuming FMA exe unit's midResult input, together with its waitForAdd control.
- It is the receiving and forwarding end of the fmaMid interface: between producer and consumer it holds, flushes on redirect, and replays.

Parameters:
- DEPTH, 2, number of buffered mid results (power of 2, >=2)
- ROB_W, 5, robIdx value width
- EXP_W, 11, fp_prod_exp width
- SIG_W, 105, fp_prod_sig width

Ports:
- clock  in  1  sole clock
- reset  in  1  asynchronous, active-low reset
- enq_valid  in  1  producer mid result valid
- enq_ready  out  1  buffer can accept
- enq_sign  in  1  fp_prod_sign
- enq_exp  in  EXP_W  fp_prod_exp
- enq_sig  in  SIG_W  fp_prod_sig
- enq_isNaN, enq_isInf, enq_isInv, enq_overflow  in  1 each  inter flags
- enq_robIdx_flag  in  1  owning uop rob flag
- enq_robIdx_value  in  ROB_W  owning uop rob value
- redirect_valid  in  1  flush request
- redirect_robIdx_flag  in  1
- redirect_robIdx_value  in  ROB_W
- redirect_level  in  1  1 = flush the redirecting uop itself too
- mid_valid  out  1  to consumer midResult_in_valid
- mid_ready  in  1  consumer consumes head this cycle
- mid_sign, mid_exp, mid_sig, mid_isNaN, mid_isInf, mid_isInv, mid_overflow  out  widths as enq_*
- mid_robIdx_flag, mid_robIdx_value  out  1 / ROB_W  head owner
- waitForAdd  out  1  to consumer midResult_waitForAdd
- count  out  log2(DEPTH)+1  occupied slots, including killed-but-unpopped slots

Behaviour:
- Storage: circular buffer of DEPTH slots.
  - Per slot: payload, robIdx, alive bit.
  - Pointers head/tail are log2(DEPTH)+1 bits (extra wrap bit).
  - full = (head^tail)==DEPTH; empty = head==tail.
- Reset (async, reset low): head=tail=0, all alive=0. Output values during reset:
  - enq_ready=1, mid_valid=0, waitForAdd=0, count=0.
  - Payload outputs are don't-care but must not be X in sim; drive 0 from the reset slot contents.
- Enqueue:
  - enq_ready = !full (no same-cycle dequeue bypass).
  - Fire = enq_valid && enq_ready: write slot[tail], alive=!killIn, tail++.
  - If killIn, the slot is still consumed, so order is preserved.
- Kill predicate kill(r), computed per entry:
  - redirect_valid && (isAfter(r, redir) || (level && r==redir)).
  - isAfter(a,b) = (a.flag ^ b.flag) ^ (a.value > b.value).
- Redirect: every slot with kill true has its alive bit cleared in the same cycle.
- Output latency: 1 cycle. An entry enqueued in cycle N is visible at the head at earliest in cycle N+1.
- mid_valid = !empty && slot[head].alive && !kill(slot[head]). Payload outputs = slot[head].
- Pop (head++, at most one per cycle) when !empty and either:
  - mid_valid && mid_ready, or
  - slot[head] is not alive (dead head auto-drains, one per cycle).
- waitForAdd = OR over occupied slots of (alive && !kill): there is still a mid result pending for the adder.
- Simultaneous events:
  - Enqueue and pop in the same cycle are both applied; count unchanged.
  - Redirect killing the head in the cycle mid_ready=1: no consume; the slot is drained as dead next cycle.
  - Wrap-around: pointer wrap bits toggle at DEPTH.
  - Full with pop: enq_ready stays 0 this cycle and rises next cycle.
- mid_ready while mid_valid=0 is ignored.
- Assertion: enq_valid while !enq_ready is a protocol error (flag in sim); the producer must hold.

Decomposition:
- Shared package (fma_mid_pkg):
  - mid-result struct (sign, exp, sig, 4 flags)
  - robIdx struct
  - EXP_W/SIG_W constants
  - isAfter / flush-check function; reused by all redirect-aware blocks
- One natural sub-module: fma_mid_flush_cmp, the combinational kill predicate, instantiated DEPTH+1 times (DEPTH slots plus the enqueue path).

Test Plan:
- Basic enqueue/dequeue, mid_ready=1: enqueue sign=1, exp=0x3FF, sig=1<<104, rob(0,3) in cycle 0.
  - Cycle 1: mid_valid=1 with identical payload, waitForAdd=1.
  - Cycle 2: count=0, waitForAdd=0.
- Full and back-pressure, DEPTH=2, mid_ready=0: enqueue rob 1 and 2 → count=2, enq_ready=0.
  - Third enq_valid is held. Assert mid_ready for one cycle: rob1 pops, enq_ready=1 next cycle.
- Redirect flushes younger entries: entries rob(0,4) and (0,6), redirect (0,5) level=0.
  - Head rob4 stays valid; rob6 killed; waitForAdd follows.
  - After rob4 pops, the dead slot drains in 1 cycle and count reaches 0.
- level=1 kills the head itself: head rob(0,5), redirect (0,5) level=1 with mid_ready=1 in the same cycle.
  - mid_valid=0 that cycle, no consume; next cycle count drops by 1.
- Wrap-around of the robIdx flag: entry rob(1,1), redirect (0,30) level=0 → entry killed (isAfter true).
  - Entry rob(0,29) with the same redirect → retained.
- Reset mid-operation: with 2 entries held, pull reset low asynchronously between clock edges.
  - Immediately mid_valid=0, waitForAdd=0, count=0, enq_ready=1.
  - After release, normal enqueue works.
